// File: rtl/fetch_pc_gen.sv
// Fetch PC generator: issues sequential imem fetches, pairs responses with PCs in an
// in-order queue, and flushes on redirect. Optional macro: FETCH_PC_MISALIGN_TRAP_EN.
module fetch_pc_gen #(
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = {DATA_WIDTH{1'b0}},
  parameter int                    INSTR_BYTES  = 4,
  parameter int                    DEPTH        = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [DATA_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data,
  output logic                  if_valid,
  input  logic                  if_ready,
  output logic [DATA_WIDTH-1:0] if_pc,
  output logic [DATA_WIDTH-1:0] if_instr,
  output logic                  misalign_o,
  output logic [DATA_WIDTH-1:0] misalign_addr
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [DATA_WIDTH-1:0] LOW_MASK = DATA_WIDTH'(INSTR_BYTES - 1);
  localparam logic [DATA_WIDTH-1:0] PC_STEP  = DATA_WIDTH'(INSTR_BYTES);
  localparam logic [DATA_WIDTH-1:0] ZERO_W   = {DATA_WIDTH{1'b0}};
  localparam logic [CW-1:0]         FULL_C   = CW'(DEPTH);
  localparam logic [CW-1:0]         ZERO_C   = {CW{1'b0}};
  localparam logic [CW-1:0]         ONE_C    = CW'(1);
  localparam logic [PW-1:0]         PTR_ZERO = {PW{1'b0}};
  localparam logic [PW-1:0]         PTR_ONE  = PW'(1);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t                state_r;
  state_t                state_nx_s;
  logic [DATA_WIDTH-1:0] pc_r;
  logic [DATA_WIDTH-1:0] q_pc_r    [DEPTH];
  logic [DATA_WIDTH-1:0] q_instr_r [DEPTH];
  logic [DEPTH-1:0]      q_filled_r;
  logic [PW-1:0]         alloc_ptr_r;
  logic [PW-1:0]         fill_ptr_r;
  logic [PW-1:0]         head_ptr_r;
  logic [CW-1:0]         count_r;
  logic [CW-1:0]         inflight_r;
  logic [CW-1:0]         drop_cnt_r;
  logic [CW-1:0]         drop_nx_s;
  logic [CW-1:0]         unret_s;
  logic                  redir_s;
  logic                  req_valid_s;
  logic                  push_s;
  logic                  fill_s;
  logic                  pop_s;
  logic                  head_valid_s;

  // Per-cycle transaction decode; a redirect suppresses queue effects of fills and pops.
  always_comb begin
    redir_s      = redirect_valid && (state_r != BOOT);
    req_valid_s  = (state_r == RUN) && (count_r < FULL_C) && !redirect_valid;
    push_s       = req_valid_s && imem_req_ready;
    head_valid_s = q_filled_r[head_ptr_r];
    fill_s       = imem_rsp_valid && (drop_cnt_r == ZERO_C) && !redir_s;
    pop_s        = head_valid_s && if_ready && !redir_s;
    if (imem_rsp_valid) begin
      unret_s = inflight_r - ONE_C;
    end else begin
      unret_s = inflight_r;
    end
  end

  // Next state and stale-response drop count.
  always_comb begin
    state_nx_s = state_r;
    drop_nx_s  = drop_cnt_r;
    if (redir_s) begin
      drop_nx_s  = unret_s;
      state_nx_s = (unret_s != ZERO_C) ? FLUSH : RUN;
    end else begin
      case (state_r)
        BOOT:  state_nx_s = RUN;
        RUN:   state_nx_s = RUN;
        FLUSH: begin
          if (imem_rsp_valid) begin
            drop_nx_s  = drop_cnt_r - ONE_C;
            state_nx_s = (drop_cnt_r == ONE_C) ? RUN : FLUSH;
          end else begin
            state_nx_s = FLUSH;
          end
        end
        default: begin
          state_nx_s = BOOT;
          drop_nx_s  = ZERO_C;
        end
      endcase
    end
  end

  // State and drop-count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= BOOT;
      drop_cnt_r <= ZERO_C;
    end else begin
      state_r    <= state_nx_s;
      drop_cnt_r <= drop_nx_s;
    end
  end

  // Requests still owed by memory, live or stale; a response always retires one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_r <= ZERO_C;
    end else begin
      inflight_r <= inflight_r + (push_s ? ONE_C : ZERO_C) - (imem_rsp_valid ? ONE_C : ZERO_C);
    end
  end

  // PC register and the in-order fetch queue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_r        <= RESET_VECTOR;
      alloc_ptr_r <= PTR_ZERO;
      fill_ptr_r  <= PTR_ZERO;
      head_ptr_r  <= PTR_ZERO;
      count_r     <= ZERO_C;
      q_filled_r  <= {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        q_pc_r[i]    <= ZERO_W;
        q_instr_r[i] <= ZERO_W;
      end
    end else if (redir_s) begin
      pc_r        <= redirect_pc & ~LOW_MASK;
      alloc_ptr_r <= PTR_ZERO;
      fill_ptr_r  <= PTR_ZERO;
      head_ptr_r  <= PTR_ZERO;
      count_r     <= ZERO_C;
      q_filled_r  <= {DEPTH{1'b0}};
    end else begin
      if (push_s) begin
        q_pc_r[alloc_ptr_r]     <= pc_r;
        q_filled_r[alloc_ptr_r] <= 1'b0;
        alloc_ptr_r             <= alloc_ptr_r + PTR_ONE;
        pc_r                    <= pc_r + PC_STEP;
      end
      if (fill_s) begin
        q_instr_r[fill_ptr_r]  <= imem_rsp_data;
        q_filled_r[fill_ptr_r] <= 1'b1;
        fill_ptr_r             <= fill_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        q_filled_r[head_ptr_r] <= 1'b0;
        head_ptr_r             <= head_ptr_r + PTR_ONE;
      end
      if (push_s && !pop_s) begin
        count_r <= count_r + ONE_C;
      end else if (pop_s && !push_s) begin
        count_r <= count_r - ONE_C;
      end
    end
  end

  assign imem_req_valid = req_valid_s;
  assign imem_req_addr  = pc_r;
  assign if_valid       = head_valid_s;
  assign if_pc          = q_pc_r[head_ptr_r];
  assign if_instr       = q_instr_r[head_ptr_r];

`ifdef FETCH_PC_MISALIGN_TRAP_EN
  logic                  misalign_r;
  logic [DATA_WIDTH-1:0] misalign_addr_r;
  logic                  misaligned_s;

  assign misaligned_s = (redirect_pc & LOW_MASK) != ZERO_W;

  // One-cycle pulse and sticky capture of the raw misaligned target.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_r      <= 1'b0;
      misalign_addr_r <= ZERO_W;
    end else if (redir_s && misaligned_s) begin
      misalign_r      <= 1'b1;
      misalign_addr_r <= redirect_pc;
    end else begin
      misalign_r      <= 1'b0;
    end
  end

  assign misalign_o    = misalign_r;
  assign misalign_addr = misalign_addr_r;
`else
  assign misalign_o    = 1'b0;
  assign misalign_addr = ZERO_W;
`endif

endmodule
